// File: rtl/hamming_sec_decoder.sv
// Serial single-error-correcting Hamming decoder: scans one codeword bit per cycle to build
// the syndrome, flips the indicated bit, and presents the corrected word and its data bits.
module hamming_sec_decoder #(
  parameter  int M     = 3,
  parameter  int CNT_W = 16,
  localparam int N     = (1 << M) - 1,
  localparam int K     = N - M
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_word,
  output logic [K-1:0]     out_data,
  output logic [M-1:0]     out_syndrome,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // out_valid, once raised, holds with stable payload until that edge; in_ready is high only in IDLE.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [M-1:0] LAST_POS = M'(N);

  state_t       state;
  logic [N-1:0] word;
  logic [M-1:0] syn;
  logic [M-1:0] idx;
  logic [N-1:0] flip_mask;

  assign dbg_state = state;

  // A syndrome s in 1..N always names a real bit because N = 2^M-1.
  assign flip_mask = (syn == '0) ? '0 : ({{(N-1){1'b0}}, 1'b1} << (syn - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_word     <= '0;
      out_syndrome <= '0;
      out_err      <= 1'b0;
      err_count    <= '0;
      word         <= '0;
      syn          <= '0;
      idx          <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            word     <= in_word;
            syn      <= '0;
            idx      <= M'(1);
            in_ready <= 1'b0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (word[idx - 1'b1]) syn <= syn ^ idx;
          idx <= idx + 1'b1;
          if (idx == LAST_POS) state <= FIX;
        end
        FIX: begin
          out_word     <= word ^ flip_mask;
          out_syndrome <= syn;
          out_err      <= (syn != '0);
          out_valid    <= 1'b1;
          if ((syn != '0) && (err_count != '1)) err_count <= err_count + 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data bits live at the non-power-of-two positions; position p lands at index p-1-clog2(p+1).
  for (genvar p = 1; p <= N; p++) begin : g_data
    if ((p & (p - 1)) != 0) begin : g_bit
      assign out_data[p - 1 - $clog2(p + 1)] = out_word[p - 1];
    end
  end

endmodule

// File: tb/tb_hamming_sec_decoder.sv
// Randomized bench for hamming_sec_decoder: a 16-bit-counter instance and a 2-bit-counter
// instance run in lockstep against a position-arithmetic reference model.
module tb_hamming_sec_decoder;
  localparam int M = 3;
  localparam int N = (1 << M) - 1;
  localparam int K = N - M;

  logic clk, rst_n, in_valid, out_ready;
  logic [N-1:0] in_word;
  logic in_ready, out_valid, out_err;
  logic [N-1:0] out_word;
  logic [K-1:0] out_data;
  logic [M-1:0] out_syndrome;
  logic [15:0] err_count;
  logic [1:0] dbg_state;

  logic s_in_ready, s_out_valid, s_out_err;
  logic [N-1:0] s_out_word;
  logic [K-1:0] s_out_data;
  logic [M-1:0] s_out_syndrome;
  logic [1:0] s_err_count;
  logic [1:0] s_dbg_state;

  int checks = 0;
  int failures = 0;
  int model_cnt = 0;
  logic [N-1:0] exp_q[$];

  hamming_sec_decoder #(.M(M), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_data(out_data),
    .out_syndrome(out_syndrome), .out_err(out_err), .err_count(err_count), .dbg_state(dbg_state)
  );

  hamming_sec_decoder #(.M(M), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_word(in_word),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_word(s_out_word), .out_data(s_out_data),
    .out_syndrome(s_out_syndrome), .out_err(s_out_err), .err_count(s_err_count),
    .dbg_state(s_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // reference model: syndrome is the XOR of the indices of all set positions
  function automatic int model_syn(input logic [N-1:0] w);
    int s = 0;
    for (int p = 1; p <= N; p++) if (w[p-1]) s = s ^ p;
    return s;
  endfunction

  function automatic logic [N-1:0] model_fix(input logic [N-1:0] w);
    logic [N-1:0] r = w;
    int s = model_syn(w);
    if (s != 0) r[s-1] = ~r[s-1];
    return r;
  endfunction

  function automatic logic [K-1:0] model_data(input logic [N-1:0] w);
    logic [K-1:0] d = '0;
    int j = 0;
    for (int p = 1; p <= N; p++) begin
      if ($countones(p) != 1) begin
        d[j] = w[p-1];
        j++;
      end
    end
    return d;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // driver: send one word, check latency/result, optionally stall the output for 'hold' cycles
  task automatic run_word(input logic [N-1:0] w, input int hold);
    int lat;
    bit got;
    logic [N-1:0] exp_w;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    check("in_ready_wait", {31'd0, got}, 32'd1);
    if (!got) return;
    in_valid = 1'b1;
    in_word  = w;
    exp_q.push_back(model_fix(w));
    @(posedge clk);
    #1;
    in_valid = (hold > 0);
    in_word  = ~w;
    check("in_ready_low", {31'd0, in_ready}, 32'd0);
    lat = 0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) begin
        got = 1;
        break;
      end
    end
    check("latency", lat, got ? N + 1 : 0);
    if (!got) return;
    exp_w = exp_q.pop_front();
    if (model_syn(w) != 0) model_cnt++;
    check("out_word", out_word, exp_w);
    check("out_data", out_data, model_data(exp_w));
    check("out_syndrome", out_syndrome, model_syn(w));
    check("out_err", out_err, (model_syn(w) != 0));
    check("err_count", err_count, sat(model_cnt, 65535));
    check("sat_err_count", s_err_count, sat(model_cnt, 3));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_word", out_word, exp_w);
      check("hold_syn", out_syndrome, model_syn(w));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("hs_valid_low", out_valid, 0);
    check("hs_in_ready", in_ready, 1);
    check("persist_word", out_word, exp_w);
  endtask

  initial begin
    logic [N-1:0] raw, cw, w;
    int kind;
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_word = '0;
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word", out_word, 0);
    check("rst_err_count", err_count, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", in_ready, 1);

    // directed anchors from known codewords
    run_word(7'h55, 0);
    check("clean_word", out_word, 7'h55);
    check("clean_data", out_data, 4'b1011);
    check("clean_syn", out_syndrome, 0);
    check("clean_cnt", err_count, 0);
    run_word(7'h75, 0);
    check("pos6_word", out_word, 7'h55);
    check("pos6_syn", out_syndrome, 6);
    check("pos6_cnt", err_count, 1);
    for (int p = 1; p <= N; p++) begin
      w = 7'h55;
      w[p-1] = ~w[p-1];
      run_word(w, 0);
      check("sweep_syn", out_syndrome, p);
      check("sweep_word", out_word, 7'h55);
    end
    run_word(7'h55 ^ 7'h08, 5);
    run_word(7'h56, 0);
    check("dbl_syn", out_syndrome, 3);
    check("dbl_word", out_word, 7'h52);
    check("dbl_data", out_data, 4'b1010);

    // reset while a word is being scanned
    @(negedge clk);
    in_valid = 1'b1;
    in_word  = 7'h75;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_word", out_word, 0);
    check("mid_rst_syn", out_syndrome, 0);
    check("mid_rst_err", out_err, 0);
    check("mid_rst_cnt", err_count, 0);
    check("mid_rst_sat_cnt", s_err_count, 0);
    exp_q.delete();
    model_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rel_ready", in_ready, 1);
    seen = 0;
    repeat (N + 3) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check("no_ghost_output", {31'd0, seen}, 0);

    // saturation: five erroneous words
    for (int i = 1; i <= 5; i++) run_word(7'h55 ^ (7'h01 << (i - 1)), 0);
    check("sat_cnt3", s_err_count, 3);
    check("wide_cnt5", err_count, 5);

    // random words: clean codewords, single errors and arbitrary patterns
    for (int i = 0; i < 40; i++) begin
      raw  = N'($urandom_range(2**N - 1, 0));
      cw   = model_fix(raw);
      kind = $urandom_range(2, 0);
      if (kind == 0) w = cw;
      else if (kind == 1) w = cw ^ (N'(1) << $urandom_range(N - 1, 0));
      else w = raw;
      run_word(w, $urandom_range(3, 0));
    end
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
